// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified memory port arbiter.
// Holds the FSM state encoding, the grant encoding and the default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DATA  = 2'b10
    } state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and muxed-field signals around the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);
    localparam int BE_W = DATA_W / 8;

    // Handshake: a requester raises *_req with stable fields and holds it until
    // its one-cycle *_ready pulse. Toward memory, mem_valid/mem_we and the muxed
    // fields stay stable until the cycle in which mem_ready is high; that edge
    // completes the transfer and mem_rdata is sampled on it.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              addr_sel;
    logic              mem_valid;
    logic              mem_we;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ready, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, addr_sel,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ready, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, addr_sel,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

endinterface

// File: rtl/mux_2x1_nbit.sv
// Plain parameterized 2:1 multiplexer: y = sel ? b : a.
module mux_2x1_nbit #(
    parameter int W = 1
) (
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// the data stage; one transaction at a time, alternating grants on a tie.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output state_t              dbg_state_o
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] FETCH_WDATA = '0;
    localparam logic [BE_W-1:0]   FETCH_BE    = '1;

    state_t            state_q;
    logic              last_grant_q;
    logic              addr_sel_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic              if_ready_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic if_elig;
    logic d_elig;
    logic grant_d;

    // A req still high in its own ready cycle is the stale hold-over, not a new request.
    assign if_elig = bus.if_req && !if_ready_q;
    assign d_elig  = bus.d_req  && !d_ready_q;
    assign grant_d = (if_elig && d_elig) ? ~last_grant_q : d_elig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_FETCH;
            addr_sel_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (if_elig || d_elig) begin
                        state_q      <= (grant_d == GNT_DATA) ? ST_DATA : ST_FETCH;
                        addr_sel_q   <= grant_d;
                        mem_valid_q  <= 1'b1;
                        mem_we_q     <= (grant_d == GNT_DATA) && bus.d_we;
                        last_grant_q <= grant_d;
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        if_rdata_q  <= bus.mem_rdata;
                        if_ready_q  <= 1'b1;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // Loads and stores both capture; store read data is don't-care downstream.
                    if (bus.mem_ready) begin
                        d_rdata_q   <= bus.mem_rdata;
                        d_ready_q   <= 1'b1;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    mem_valid_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_sel  = addr_sel_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;

    mux_2x1_nbit #(.W(ADDR_W)) u_addr_mux (
        .sel_i (addr_sel_q),
        .a_i   (bus.if_addr),
        .b_i   (bus.d_addr),
        .y_o   (bus.mem_addr)
    );

    mux_2x1_nbit #(.W(DATA_W)) u_wdata_mux (
        .sel_i (addr_sel_q),
        .a_i   (FETCH_WDATA),
        .b_i   (bus.d_wdata),
        .y_o   (bus.mem_wdata)
    );

    mux_2x1_nbit #(.W(BE_W)) u_be_mux (
        .sel_i (addr_sel_q),
        .a_i   (FETCH_BE),
        .b_i   (bus.d_be),
        .y_o   (bus.mem_be)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner-case sequences
// and a read-data scoreboard fed by the memory responder.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DATA_W = 32;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          waits;
        bit          exp_sel;
        bit          exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int pulses = 0;
    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W:0]   mon_e;
    logic [DATA_W-1:0] last_if;
    logic [DATA_W-1:0] last_d;
    vec_t vecs[8];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && (bus.if_ready || bus.d_ready)) begin
            pulses++;
            check("ready_exclusive", {bus.if_ready, bus.d_ready} == 2'b11, 1'b0);
            check("ready_has_expect", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("ready_port", bus.d_ready, mon_e[DATA_W]);
                check("rdata", bus.d_ready ? bus.d_rdata : bus.if_rdata, mon_e[DATA_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_valid"}, bus.mem_valid, 1'b0);
        check({tag, "_mem_we"}, bus.mem_we, 1'b0);
        check({tag, "_addr_sel"}, bus.addr_sel, 1'b0);
        check({tag, "_readys"}, {bus.if_ready, bus.d_ready}, 2'b00);
        check({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
        check({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // Memory side: wait for mem_valid, check fields, insert wait states, complete.
    // Returns at the negedge of the ready cycle.
    task automatic respond(input bit sel, input bit we_exp, input logic [31:0] addr,
                           input logic [31:0] wdata_exp, input logic [3:0] be_exp,
                           input logic [31:0] rdata, input int waits, output int gap);
        int n = 0;
        while (!bus.mem_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        gap = n;
        check("mem_valid_seen", bus.mem_valid, 1'b1);
        check("addr_sel", bus.addr_sel, sel);
        check("mem_we", bus.mem_we, we_exp);
        check("mem_addr", bus.mem_addr, addr);
        check("mem_wdata", bus.mem_wdata, wdata_exp);
        check("mem_be", bus.mem_be, be_exp);
        check("busy", bus.busy, 1'b1);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("hold_fields", {bus.mem_valid, bus.addr_sel, bus.mem_we, bus.mem_addr,
                                  bus.mem_wdata[15:0], bus.mem_be},
                  {1'b1, sel, we_exp, addr, wdata_exp[15:0], be_exp});
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        exp_q.push_back({sel, rdata});
        pushed++;
        if (sel) last_d = rdata;
        else last_if = rdata;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        check("valid_cleared", {bus.mem_valid, bus.mem_we}, 2'b00);
        check("if_ready_pulse", bus.if_ready, !sel);
        check("d_ready_pulse", bus.d_ready, sel);
    endtask

    task automatic do_txn(input vec_t v);
        int gap;
        @(negedge clk);
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
            bus.d_wdata = v.wdata; bus.d_be = v.be;
            bus.if_addr = $urandom;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
            bus.d_we = 1'b1; bus.d_addr = $urandom;
            bus.d_wdata = v.wdata; bus.d_be = v.be;
        end
        @(negedge clk);
        respond(v.exp_sel, v.exp_we, v.addr, v.exp_wdata, v.exp_be, v.rdata, v.waits, gap);
        check("grant_latency", gap, 0);
        // req is still held over the ready-cycle edge: must not restart
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        check("no_stale_restart", {bus.mem_valid, bus.busy}, 2'b00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        last_if = '0; last_d = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h1234_5678, 4'b0101, 32'h0050_0093, 0,
                    1'b0, 1'b0, 32'h0, 4'hF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h5A5A_0001, 3,
                    1'b1, 1'b1, 32'hDEAD_BEEF, 4'b0011};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hA1B2_C3D4, 1,
                    1'b1, 1'b0, 32'hCAFE_F00D, 4'b1111};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0113, 2,
                    1'b0, 1'b0, 32'h0, 4'hF};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_00FF, 4'b1000, 32'h0, 0,
                    1'b1, 1'b1, 32'h0000_00FF, 4'b1000};
        for (int i = 5; i < 8; i++) begin
            vecs[i].is_d  = 1'($urandom_range(0, 1));
            vecs[i].we    = 1'($urandom_range(0, 1));
            vecs[i].addr  = $urandom;
            vecs[i].wdata = $urandom;
            vecs[i].be    = 4'($urandom_range(0, 15));
            vecs[i].rdata = $urandom;
            vecs[i].waits = $urandom_range(0, 4);
            vecs[i].exp_sel   = vecs[i].is_d;
            vecs[i].exp_we    = vecs[i].is_d & vecs[i].we;
            vecs[i].exp_wdata = vecs[i].is_d ? vecs[i].wdata : 32'h0;
            vecs[i].exp_be    = vecs[i].is_d ? vecs[i].be : 4'hF;
        end

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // mem_ready while idle is ignored
        @(negedge clk);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("idle_ready_no_valid", {bus.mem_valid, bus.if_ready, bus.d_ready}, 3'b000);
        check("idle_ready_if_rdata", bus.if_rdata, last_if);
        check("idle_ready_d_rdata", bus.d_rdata, last_d);

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        @(negedge clk);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("idle_ready2_if_rdata", bus.if_rdata, last_if);
        check("idle_ready2_d_rdata", bus.d_rdata, last_d);

        // Reset in the middle of a DATA store
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
        bus.d_wdata = 32'h1111_2222; bus.d_be = 4'hF;
        @(negedge clk);
        check("pre_reset_valid", {bus.mem_valid, bus.addr_sel, bus.mem_we}, 3'b111);
        #2 rst = 1'b1;
        #1 check("async_valid_drop", bus.mem_valid, 1'b0);
        check_reset_outputs("mid_rst");
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h9999_9999;
        @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.d_req = 1'b0;
        rst = 1'b0;
        last_if = '0; last_d = '0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Tie from reset: DATA first, FETCH immediately after, no idle gap
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800; bus.d_be = 4'h3;
        @(negedge clk);
        respond(1'b1, 1'b0, 32'h800, bus.d_wdata, 4'h3, 32'hD0D0_0001, 1, gap);
        check("tie1_gap", gap, 0);
        @(negedge clk);
        bus.d_req = 1'b0;
        respond(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 32'hF0F0_0002, 0, gap);
        check("tie1_fetch_no_gap", gap, 0);
        @(negedge clk);
        bus.if_req = 1'b0;
        check("tie1_idle", bus.mem_valid, 1'b0);

        // Further tie after FETCH: DATA wins again
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h804;
        bus.d_wdata = 32'h0102_0304; bus.d_be = 4'hC;
        @(negedge clk);
        respond(1'b1, 1'b1, 32'h804, 32'h0102_0304, 4'hC, 32'hD0D0_0003, 0, gap);
        check("tie2_gap", gap, 0);
        @(negedge clk);
        bus.d_req = 1'b0;
        respond(1'b0, 1'b0, 32'h44, 32'h0, 4'hF, 32'hF0F0_0004, 2, gap);
        check("tie2_fetch_no_gap", gap, 0);
        @(negedge clk);
        bus.if_req = 1'b0;
        check("tie2_idle", {bus.mem_valid, bus.busy}, 2'b00);

        repeat (3) @(negedge clk);
        check("pulse_count", pulses, pushed);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between instruction fetch (IF) and the data stage (MEM).
- Generates the registered `addr_sel` that drives the 2:1 address, write-data and byte-enable multiplexers placed directly downstream of it.
- Sequences one memory transaction at a time with a valid/ready handshake.
- Returns read data and a one-cycle ready pulse to the granted requester.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_rdata  out  DATA_W  registered fetch read data
- if_ready  out  1  one-cycle pulse; fetch complete
- d_req  in  1  data request; held high until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  registered load data
- d_ready  out  1  one-cycle pulse; data access complete
- addr_sel  out  1  registered mux select: 0 = IF fields, 1 = data fields
- mem_valid  out  1  transaction valid toward memory
- mem_we  out  1  write strobe; only ever high with mem_valid
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready high
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - state = IDLE; every output = 0, including rdata registers and last_grant.
  - mem_valid drops without waiting for the clock.
  - An in-flight mem_ready arriving during reset is ignored.
- States: IDLE, FETCH, DATA (2-bit encoding).
- Eligibility: a requester is eligible in IDLE only if its req is high and its ready is not high in the same cycle. This masks the stale req held over the completion cycle.
- IDLE arbitration:
  - Only one eligible requester: grant it.
  - Both eligible: grant the requester opposite last_grant. Reset value of last_grant is FETCH, so data wins the first tie.
  - On grant, the next edge registers: state, addr_sel (FETCH→0, DATA→1), mem_valid = 1, mem_we = (DATA & d_we), last_grant.
- FETCH/DATA:
  - Hold mem_valid, mem_we and addr_sel stable while mem_ready is low. Unbounded wait; no timeout.
  - Edge with mem_ready high:
    - Capture mem_rdata into if_rdata or d_rdata (d_rdata is also captured on stores; the value is don't-care to the pipeline).
    - Pulse the matching ready for exactly one cycle.
    - Clear mem_valid and mem_we.
    - Return to IDLE.
- Latency:
  - Request seen in IDLE at edge N → mem_valid high after N.
  - mem_ready at edge M → ready pulse and rdata valid in cycle M+1.
  - Zero-wait memory gives 2 cycles per access.
  - Back-to-back: IDLE in the ready cycle may grant the other requester immediately.
- addr_sel keeps its last value in IDLE; it never toggles while mem_valid is high.
- Requester dropping req mid-transaction: the transaction completes anyway and the ready pulse is still issued.
- mem_ready while IDLE: ignored.
- if_ready and d_ready are never high in the same cycle.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding constants ST_IDLE = 2'b00, ST_FETCH = 2'b01, ST_DATA = 2'b10
  - grant constants GNT_FETCH = 1'b0, GNT_DATA = 1'b1
  - default ADDR_W and DATA_W
- One sub-module, `mux_2x1_nbit` (parameterized width), instantiated three times:
  - address select (IF vs data fields)
  - write-data select (fetch side fixed 0)
  - byte-enable select (fetch side fixed all-ones)
- Remaining logic is the FSM plus the output registers.

Test Plan:
- Reset: rst pulsed mid-DATA with mem_valid = 1 → mem_valid = 0 within the same cycle (before the next edge); all outputs 0; state IDLE; subsequent mem_ready ignored.
- Single fetch, zero-wait: if_req = 1, if_addr = 0x0000_0010; mem_rdata = 0x0050_0093 with mem_ready in the first valid cycle → addr_sel = 0, mem_we = 0, if_ready pulses once 2 cycles after request, if_rdata = 0x0050_0093.
- Store with 3 wait states: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_be = 4'b0011 → mem_valid stays high 4 cycles with stable fields, mem_we = 1, addr_sel = 1, d_ready pulses once.
- Simultaneous requests from reset: if_req and d_req both high → DATA granted first, FETCH second with no idle gap; on a further tie after FETCH, DATA is granted.
- Stale-req masking: requester holds req one cycle past its ready pulse → no duplicate transaction; exactly one mem_valid episode per request.
- mem_ready asserted in IDLE with no request → no ready pulse; rdata registers unchanged.
